// File: rtl/noc_pkg.sv
// ============================================================================
// noc_pkg : shared flit layout helpers, mode encodings and FSM state type
// Revision: 1.0
// ============================================================================
`default_nettype none

package noc_pkg;

  localparam logic [1:0] MODE_UNIFORM = 2'd0;
  localparam logic [1:0] MODE_BITCOMP = 2'd1;
  localparam logic [1:0] MODE_FIXED   = 2'd2;
  localparam logic [1:0] MODE_RR      = 2'd3;

  // Right-shifting Galois mask for x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GEN  = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } pe_state_e;

  // Flit layout, MSB first: dest | src | seq | payload
  function automatic int f_dest_msb(input int data_w);
    return data_w - 1;
  endfunction

  function automatic int f_dest_lsb(input int data_w, input int addr_w);
    return data_w - addr_w;
  endfunction

  function automatic int f_src_lsb(input int data_w, input int addr_w);
    return data_w - 2 * addr_w;
  endfunction

  function automatic int f_seq_lsb(input int data_w, input int addr_w, input int seq_w);
    return data_w - 2 * addr_w - seq_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/noc_lfsr32.sv
// ============================================================================
// noc_lfsr32 : seedable 32-bit Galois LFSR with advance enable
// Revision: 1.0
// ============================================================================
`default_nettype none

module noc_lfsr32
  import noc_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h0000_0001
) (
  input  logic        sclk,
  input  logic        rst,
  input  logic        i_enable,
  output logic [31:0] o_state
);

  logic [31:0] state_q;
  logic [31:0] state_d;

  always_comb begin
    state_d = state_q;
    if (i_enable) begin
      state_d = (state_q >> 1) ^ (state_q[0] ? LFSR_TAPS : 32'h0);
    end
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign o_state = state_q;

endmodule

`default_nettype wire

// File: rtl/noc_traffic_pe.sv
// ============================================================================
// noc_traffic_pe : traffic-generating and checking PE for one NoC leaf port
// Revision: 1.0
// ============================================================================
`default_nettype none

module noc_traffic_pe
  import noc_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          NUM_NODES = 4,
  parameter int          ADDR_W    = $clog2(NUM_NODES),
  parameter int          ADDR      = 0,
  parameter int          SEQ_W     = 8,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_0001 ^ 32'(ADDR)
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              i_enable,
  input  logic [1:0]        i_mode,
  input  logic [ADDR_W-1:0] i_fixed_dest,
  input  logic [7:0]        i_rate,
  input  logic [31:0]       i_max_pkts,
  input  logic              i_rx_stall,
  output logic [DATA_W-1:0] o_data,
  output logic              o_data_valid,
  input  logic              i_data_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_data_valid,
  output logic              o_data_ready,
  output logic [31:0]       o_sent_cnt,
  output logic [31:0]       o_recv_cnt,
  output logic [31:0]       o_err_cnt,
  output logic              o_done
);

  localparam int DEST_LSB = f_dest_lsb(DATA_W, ADDR_W);
  localparam int SRC_LSB  = f_src_lsb(DATA_W, ADDR_W);
  localparam int SEQ_LSB  = f_seq_lsb(DATA_W, ADDR_W, SEQ_W);

  localparam logic [ADDR_W-1:0] SELF     = ADDR_W'(ADDR);
  localparam logic [ADDR_W-1:0] RR_INIT  = ADDR_W'((ADDR + 1) % NUM_NODES);
  localparam logic [DATA_W-1:0] PAY_MASK = (DATA_W'(1) << SEQ_LSB) - DATA_W'(1);

  logic [31:0] lfsr;

  noc_lfsr32 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .sclk     (sclk),
    .rst      (rst),
    .i_enable (1'b1),
    .o_state  (lfsr)
  );

  pe_state_e         state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              rx_ready_q, rx_ready_d;
  logic [31:0]       sent_q, sent_d;
  logic [31:0]       recv_q, recv_d;
  logic [31:0]       err_q, err_d;
  logic [ADDR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [SEQ_W-1:0]  seq_tx_q [NUM_NODES];
  logic [SEQ_W-1:0]  seq_tx_d [NUM_NODES];
  logic [SEQ_W-1:0]  seq_rx_q [NUM_NODES];
  logic [SEQ_W-1:0]  seq_rx_d [NUM_NODES];

  logic [ADDR_W-1:0] gen_dest;
  logic              gen_ok;
  logic [ADDR_W-1:0] rr_next;
  logic [DATA_W-1:0] gen_flit;
  logic [ADDR_W-1:0] tx_dest;
  logic [31:0]       sent_inc;

  // Destination selection; gen_ok drops only for a fixed destination equal to self
  always_comb begin
    gen_dest = '0;
    gen_ok   = 1'b0;
    case (i_mode)
      MODE_UNIFORM: begin
        gen_dest = lfsr[ADDR_W+7:8];
        if (gen_dest == SELF) begin
          gen_dest = gen_dest + ADDR_W'(1);
        end
        gen_ok = 1'b1;
      end
      MODE_BITCOMP: begin
        gen_dest = ~SELF;
        gen_ok   = 1'b1;
      end
      MODE_FIXED: begin
        gen_dest = i_fixed_dest;
        gen_ok   = (i_fixed_dest != SELF);
      end
      default: begin
        gen_dest = rr_ptr_q;
        gen_ok   = 1'b1;
      end
    endcase
  end

  always_comb begin
    rr_next = rr_ptr_q + ADDR_W'(1);
    if (rr_next == SELF) begin
      rr_next = rr_next + ADDR_W'(1);
    end
  end

  assign gen_flit = (DATA_W'(gen_dest) << DEST_LSB)
                  | (DATA_W'(SELF) << SRC_LSB)
                  | (DATA_W'(seq_tx_q[gen_dest]) << SEQ_LSB)
                  | (DATA_W'(lfsr) & PAY_MASK);

  assign tx_dest  = data_q[DEST_LSB +: ADDR_W];
  assign sent_inc = sent_q + 32'd1;

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    valid_d  = valid_q;
    done_d   = done_q;
    sent_d   = sent_q;
    rr_ptr_d = rr_ptr_q;
    seq_tx_d = seq_tx_q;
    case (state_q)
      ST_IDLE: begin
        if (i_enable) begin
          state_d = ST_GEN;
        end
      end
      ST_GEN: begin
        if (!i_enable) begin
          state_d = ST_IDLE;
        end else if ((lfsr[7:0] < i_rate) && gen_ok) begin
          data_d  = gen_flit;
          valid_d = 1'b1;
          state_d = ST_SEND;
          if (i_mode == MODE_RR) begin
            rr_ptr_d = rr_next;
          end
        end
      end
      // Enable is deliberately ignored here so a pending flit is never dropped
      ST_SEND: begin
        if (i_data_ready) begin
          valid_d           = 1'b0;
          sent_d            = sent_inc;
          seq_tx_d[tx_dest] = seq_tx_q[tx_dest] + SEQ_W'(1);
          if ((i_max_pkts != 32'd0) && (sent_inc == i_max_pkts)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_GEN;
          end
        end
      end
      ST_DONE: begin
        if (!i_enable) begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  logic              rx_fire;
  logic [ADDR_W-1:0] rx_dest;
  logic [ADDR_W-1:0] rx_src;
  logic [SEQ_W-1:0]  rx_seq;
  logic              rx_bad;

  assign rx_fire = i_data_valid & rx_ready_q;
  assign rx_dest = i_data[DEST_LSB +: ADDR_W];
  assign rx_src  = i_data[SRC_LSB +: ADDR_W];
  assign rx_seq  = i_data[SEQ_LSB +: SEQ_W];
  assign rx_bad  = (rx_dest != SELF) || (rx_seq != seq_rx_q[rx_src]);

  // Expected sequence always follows the last seen value, so one gap costs one error
  always_comb begin
    rx_ready_d = ~i_rx_stall;
    recv_d     = recv_q;
    err_d      = err_q;
    seq_rx_d   = seq_rx_q;
    if (rx_fire) begin
      recv_d           = recv_q + 32'd1;
      err_d            = rx_bad ? (err_q + 32'd1) : err_q;
      seq_rx_d[rx_src] = rx_seq + SEQ_W'(1);
    end
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      data_q     <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      rx_ready_q <= 1'b0;
      sent_q     <= '0;
      recv_q     <= '0;
      err_q      <= '0;
      rr_ptr_q   <= RR_INIT;
      for (int i = 0; i < NUM_NODES; i++) begin
        seq_tx_q[i] <= '0;
        seq_rx_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      rx_ready_q <= rx_ready_d;
      sent_q     <= sent_d;
      recv_q     <= recv_d;
      err_q      <= err_d;
      rr_ptr_q   <= rr_ptr_d;
      seq_tx_q   <= seq_tx_d;
      seq_rx_q   <= seq_rx_d;
    end
  end

  assign o_data       = data_q;
  assign o_data_valid = valid_q;
  assign o_data_ready = rx_ready_q;
  assign o_sent_cnt   = sent_q;
  assign o_recv_cnt   = recv_q;
  assign o_err_cnt    = err_q;
  assign o_done       = done_q;

  logic unused_bits;
  assign unused_bits = ^{i_data, lfsr};

endmodule

`default_nettype wire
